// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave over a byte-enabled register store, with write forwarding to the
// datapath and a full-word datapath update port that loses to host commits on the same word.
module axi4_lite_regfile #(
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   localparam int         STRB_W     = DATA_WIDTH / 8,
   localparam int         LSB        = $clog2(STRB_W),
   localparam int         IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           awaddr,
   input  logic [2:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_W-1:0]     wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [31:0]           araddr,
   input  logic [2:0]            arprot,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  fwd_en,
   output logic [IDX_W-1:0]      fwd_idx,
   output logic [DATA_WIDTH-1:0] fwd_data,
   input  logic                  upd_valid,
   input  logic [IDX_W-1:0]      upd_idx,
   input  logic [DATA_WIDTH-1:0] upd_data,
   output logic                  upd_dropped
);

   localparam logic [32:0] SPAN   = 33'(DEPTH * STRB_W);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

   w_state_t w_state_q, w_state_d;
   r_state_t r_state_q, r_state_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [31:0]           aw_addr_q, aw_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0]     w_strb_q, w_strb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [31:0]           ar_addr_q, ar_addr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  upd_dropped_q, upd_dropped_d;

   logic                  commit;
   logic [31:0]           c_addr;
   logic [DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]     c_strb;
   logic [31:0]           c_off, r_off;
   logic                  c_in, r_in;
   logic [IDX_W-1:0]      c_idx, r_idx;
   logic                  host_we, upd_conflict;
   logic                  awready_c, wready_c, bvalid_c, arready_c, rvalid_c;

   // Protection bits carry no meaning for this block.
   logic unused_prot;
   assign unused_prot = ^{awprot, arprot};

   assign c_off = c_addr - BASE_ADDR;
   assign c_in  = (c_addr >= BASE_ADDR) && ({1'b0, c_off} < SPAN);
   assign c_idx = c_off[LSB+IDX_W-1:LSB];
   assign r_off = ar_addr_q - BASE_ADDR;
   assign r_in  = (ar_addr_q >= BASE_ADDR) && ({1'b0, r_off} < SPAN);
   assign r_idx = r_off[LSB+IDX_W-1:LSB];

   always_comb begin
      w_state_d = w_state_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      awready_c = 1'b0;
      wready_c  = 1'b0;
      bvalid_c  = 1'b0;
      commit    = 1'b0;
      c_addr    = aw_addr_q;
      c_data    = w_data_q;
      c_strb    = w_strb_q;
      case (w_state_q)
         W_IDLE: begin
            awready_c = 1'b1;
            wready_c  = 1'b1;
            if (awvalid && wvalid) begin
               commit = 1'b1;
               c_addr = awaddr;
               c_data = wdata;
               c_strb = wstrb;
            end else if (awvalid) begin
               aw_addr_d = awaddr;
               w_state_d = W_WAIT_DATA;
            end else if (wvalid) begin
               w_data_d  = wdata;
               w_strb_d  = wstrb;
               w_state_d = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: begin
            wready_c = 1'b1;
            c_data   = wdata;
            c_strb   = wstrb;
            commit   = wvalid;
         end
         W_WAIT_ADDR: begin
            awready_c = 1'b1;
            c_addr    = awaddr;
            commit    = awvalid;
         end
         W_RESP: begin
            bvalid_c = 1'b1;
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      if (commit) w_state_d = W_RESP;
      // Nothing may handshake or commit while reset is held.
      if (rst) begin
         awready_c = 1'b0;
         wready_c  = 1'b0;
         bvalid_c  = 1'b0;
         commit    = 1'b0;
      end
   end

   assign bresp_d       = commit ? (c_in ? OKAY : SLVERR) : bresp_q;
   assign host_we       = commit && c_in;
   assign upd_conflict  = upd_valid && host_we && (upd_idx == c_idx);
   assign upd_dropped_d = upd_conflict;

   // Merged word: new bytes where strobed, current contents elsewhere.
   generate
      for (genvar gi = 0; gi < STRB_W; gi++) begin : g_merge
         assign fwd_data[gi*8 +: 8] = c_strb[gi] ? c_data[gi*8 +: 8] : mem_q[c_idx][gi*8 +: 8];
      end
   endgenerate

   assign fwd_en  = host_we;
   assign fwd_idx = c_idx;

   always_comb begin
      r_state_d = r_state_q;
      ar_addr_d = ar_addr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      arready_c = 1'b0;
      rvalid_c  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            arready_c = 1'b1;
            if (arvalid) begin
               ar_addr_d = araddr;
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            rdata_d   = r_in ? mem_q[r_idx] : '0;
            rresp_d   = r_in ? OKAY : SLVERR;
            r_state_d = R_RESP;
         end
         R_RESP: begin
            rvalid_c = 1'b1;
            if (rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
      if (rst) begin
         arready_c = 1'b0;
         rvalid_c  = 1'b0;
      end
   end

   assign awready     = awready_c;
   assign wready      = wready_c;
   assign bvalid      = bvalid_c;
   assign arready     = arready_c;
   assign rvalid      = rvalid_c;
   assign bresp       = rst ? 2'b00 : bresp_q;
   assign rresp       = rst ? 2'b00 : rresp_q;
   assign rdata       = rst ? '0 : rdata_q;
   assign upd_dropped = rst ? 1'b0 : upd_dropped_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q     <= W_IDLE;
         r_state_q     <= R_IDLE;
         bresp_q       <= 2'b00;
         rdata_q       <= '0;
         rresp_q       <= 2'b00;
         upd_dropped_q <= 1'b0;
      end else begin
         w_state_q     <= w_state_d;
         r_state_q     <= r_state_d;
         bresp_q       <= bresp_d;
         rdata_q       <= rdata_d;
         rresp_q       <= rresp_d;
         upd_dropped_q <= upd_dropped_d;
      end
   end

   always_ff @(posedge clk) begin
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
   end

   // Storage is never cleared; the host write is ordered last so it wins a shared word.
   always_ff @(posedge clk) begin
      if (upd_valid && !upd_conflict) mem_q[upd_idx] <= upd_data;
      if (host_we) mem_q[c_idx] <= fwd_data;
   end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: a 32-bit instance at a non-zero base and a 64-bit instance.
module tb_axi4_lite_regfile;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, fwd_data, upd_data = '0;
   logic [3:0]  wstrb = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rvalid, rready = 0, fwd_en, upd_valid = 0, upd_dropped;
   logic [1:0]  bresp, rresp;
   logic [7:0]  fwd_idx, upd_idx = '0;

   logic [31:0] awaddr64 = '0, araddr64 = '0;
   logic [63:0] wdata64 = '0, rdata64, fwd_data64, upd_data64 = '0;
   logic [7:0]  wstrb64 = '0;
   logic        awvalid64 = 0, awready64, wvalid64 = 0, wready64, bvalid64;
   logic        arvalid64 = 0, arready64, rvalid64, fwd_en64, upd_valid64 = 0, upd_dropped64;
   logic [1:0]  bresp64, rresp64;
   logic [3:0]  fwd_idx64, upd_idx64 = '0;

   axi4_lite_regfile #(.DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(BASE)) u_dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .fwd_en(fwd_en), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_data(upd_data), .upd_dropped(upd_dropped)
   );

   axi4_lite_regfile #(.DATA_WIDTH(64), .DEPTH(16), .BASE_ADDR(32'h0)) u_dut64 (
      .clk(clk), .rst(rst),
      .awaddr(awaddr64), .awprot(awprot), .awvalid(awvalid64), .awready(awready64),
      .wdata(wdata64), .wstrb(wstrb64), .wvalid(wvalid64), .wready(wready64),
      .bresp(bresp64), .bvalid(bvalid64), .bready(1'b1),
      .araddr(araddr64), .arprot(arprot), .arvalid(arvalid64), .arready(arready64),
      .rdata(rdata64), .rresp(rresp64), .rvalid(rvalid64), .rready(1'b1),
      .fwd_en(fwd_en64), .fwd_idx(fwd_idx64), .fwd_data(fwd_data64),
      .upd_valid(upd_valid64), .upd_idx(upd_idx64), .upd_data(upd_data64), .upd_dropped(upd_dropped64)
   );

   int tests = 0;
   int fails = 0;

   // Results captured by the transaction tasks.
   logic        fe_s, bv_s, bhold_s, bdone_s, ud_pre_s, ud_s, ud_post_s;
   logic [7:0]  fi_s;
   logic [31:0] fd_s;
   logic [1:0]  br_s;
   logic        rv_early_s, rv_s;
   logic [31:0] rd_s;
   logic [1:0]  rr_s;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode 0: AW and W together; 1: W first, AW three cycles later; 2: AW first, W three cycles later.
   task automatic host_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int stall,
                          input logic uv, input logic [7:0] ui, input logic [31:0] ud);
      @(negedge clk);
      bready = 1'b0;
      if (mode == 0) begin
         awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      end else if (mode == 1) begin
         wdata = d; wstrb = s; wvalid = 1'b1;
         @(negedge clk);
         wvalid = 1'b0; wdata = '0; wstrb = '0;
         repeat (2) @(negedge clk);
         awaddr = a; awvalid = 1'b1;
      end else begin
         awaddr = a; awvalid = 1'b1;
         @(negedge clk);
         awvalid = 1'b0; awaddr = '0;
         repeat (2) @(negedge clk);
         wdata = d; wstrb = s; wvalid = 1'b1;
      end
      upd_valid = uv; upd_idx = ui; upd_data = ud;
      #1;
      fe_s = fwd_en; fi_s = fwd_idx; fd_s = fwd_data; ud_pre_s = upd_dropped;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; upd_valid = 1'b0;
      bv_s = bvalid; br_s = bresp; ud_s = upd_dropped;
      bhold_s = 1'b1;
      repeat (stall) begin
         @(negedge clk);
         if (!bvalid) bhold_s = 1'b0;
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      bdone_s = !bvalid;
      ud_post_s = upd_dropped;
   endtask

   task automatic rd(input logic [31:0] a);
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rv_early_s = rvalid;
      @(negedge clk);
      rv_s = rvalid; rd_s = rdata; rr_s = rresp;
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
      chk("rst_valid", 64'({bvalid, rvalid}), 64'd0);
      chk("rst_pulse", 64'({fwd_en, upd_dropped}), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_resp", 64'({bresp, rresp}), 64'd0);
      chk("rst_rdata64", rdata64, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 64'({awready, wready, arready}), 64'h7);

      // Simultaneous AW/W write and readback
      host_wr(BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 8'd0, 32'd0);
      chk("w1_fwd_en", 64'(fe_s), 64'd1);
      chk("w1_fwd_idx", 64'(fi_s), 64'd2);
      chk("w1_fwd_data", 64'(fd_s), 64'hDEADBEEF);
      chk("w1_bvalid", 64'(bv_s), 64'd1);
      chk("w1_bresp", 64'(br_s), 64'd0);
      chk("w1_bdone", 64'(bdone_s), 64'd1);
      rd(BASE + 32'h8);
      chk("r1_rvalid_fetch", 64'(rv_early_s), 64'd0);
      chk("r1_rvalid", 64'(rv_s), 64'd1);
      chk("r1_rdata", 64'(rd_s), 64'hDEADBEEF);
      chk("r1_rresp", 64'(rr_s), 64'd0);

      // Split handshakes, W first then AW first, with a stalled bready
      host_wr(BASE + 32'h14, 32'h11223344, 4'hF, 1, 4, 1'b0, 8'd0, 32'd0);
      chk("wsplit_fwd_en", 64'(fe_s), 64'd1);
      chk("wsplit_fwd", 64'({fi_s, fd_s}), {24'd0, 8'd5, 32'h11223344});
      chk("wsplit_bhold", 64'({bv_s, bhold_s, bdone_s}), 64'h7);
      rd(BASE + 32'h14);
      chk("wsplit_read", 64'(rd_s), 64'h11223344);
      host_wr(BASE + 32'h18, 32'h11223344, 4'hF, 2, 4, 1'b0, 8'd0, 32'd0);
      chk("awsplit_fwd", 64'({fe_s, fi_s, fd_s}), {23'd0, 1'b1, 8'd6, 32'h11223344});
      chk("awsplit_bhold", 64'({bv_s, bhold_s, bdone_s}), 64'h7);
      rd(BASE + 32'h18);
      chk("awsplit_read", 64'(rd_s), 64'h11223344);

      // Strobe merge and zero strobe
      host_wr(BASE + 32'hC, 32'hAABBCCDD, 4'hF, 0, 0, 1'b0, 8'd0, 32'd0);
      host_wr(BASE + 32'hC, 32'h00000099, 4'h1, 0, 0, 1'b0, 8'd0, 32'd0);
      chk("strb_fwd_data", 64'(fd_s), 64'hAABBCC99);
      rd(BASE + 32'hC);
      chk("strb_read", 64'(rd_s), 64'hAABBCC99);
      host_wr(BASE + 32'hC, 32'hFFFFFFFF, 4'h0, 0, 0, 1'b0, 8'd0, 32'd0);
      chk("strb0_fwd_en_bresp", 64'({fe_s, br_s}), 64'h4);
      rd(BASE + 32'hC);
      chk("strb0_read", 64'(rd_s), 64'hAABBCC99);

      // Out of range above and below the window; low address bits ignored
      host_wr(BASE, 32'h12345678, 4'hF, 0, 0, 1'b0, 8'd0, 32'd0);
      host_wr(BASE + 32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0, 8'd0, 32'd0);
      chk("oor_fwd_en", 64'(fe_s), 64'd0);
      chk("oor_bresp", 64'({bv_s, br_s}), 64'h6);
      rd(BASE);
      chk("oor_unchanged", 64'(rd_s), 64'h12345678);
      rd(BASE + 32'h400);
      chk("oor_read", 64'({rv_s, rr_s, rd_s}), {29'd0, 1'b1, 2'b10, 32'd0});
      rd(BASE - 32'h4);
      chk("below_read", 64'({rv_s, rr_s, rd_s}), {29'd0, 1'b1, 2'b10, 32'd0});
      rd(BASE + 32'hB);
      chk("lowbits_read", 64'(rd_s), 64'hDEADBEEF);

      // Host/update collision on idx 7, then disjoint indices 7 and 8
      host_wr(BASE + 32'h1C, 32'h1, 4'hF, 0, 0, 1'b1, 8'd7, 32'h2);
      chk("coll_dropped", 64'({ud_pre_s, ud_s, ud_post_s}), 64'h2);
      rd(BASE + 32'h1C);
      chk("coll_read", 64'(rd_s), 64'h1);
      host_wr(BASE + 32'h1C, 32'h77, 4'hF, 0, 0, 1'b1, 8'd8, 32'h88);
      chk("disj_dropped", 64'(ud_s), 64'd0);
      rd(BASE + 32'h1C);
      chk("disj_read7", 64'(rd_s), 64'h77);
      rd(BASE + 32'h20);
      chk("disj_read8", 64'(rd_s), 64'h88);

      // Reset asserted during R_FETCH abandons the read
      @(negedge clk);
      araddr = BASE + 32'h8; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstfetch_during", 64'({rvalid, arready}), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstfetch_after", 64'({rvalid, arready}), 64'h1);
      end

      // 64-bit instance: upper-half strobe on idx 2
      @(negedge clk);
      upd_valid64 = 1'b1; upd_idx64 = 4'd2; upd_data64 = 64'h11111111_22222222;
      @(negedge clk);
      upd_valid64 = 1'b0;
      awaddr64 = 32'h10; wdata64 = 64'hAAAAAAAA_BBBBBBBB; wstrb64 = 8'hF0;
      awvalid64 = 1'b1; wvalid64 = 1'b1;
      #1;
      chk("w64_fwd_en_idx", 64'({fwd_en64, fwd_idx64}), 64'h12);
      chk("w64_fwd_data", fwd_data64, 64'hAAAAAAAA_22222222);
      @(negedge clk);
      awvalid64 = 1'b0; wvalid64 = 1'b0;
      chk("w64_bresp", 64'({bvalid64, bresp64}), 64'h4);
      @(negedge clk);
      araddr64 = 32'h10; arvalid64 = 1'b1;
      @(negedge clk);
      arvalid64 = 1'b0;
      @(negedge clk);
      chk("r64_valid_resp", 64'({rvalid64, rresp64}), 64'h4);
      chk("r64_rdata", rdata64, 64'hAAAAAAAA_22222222);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
